// File: rtl/enemy_hp_ctrl_pkg.sv
// Shared battle definitions: state encoding, default sizing, small helpers.
package enemy_hp_ctrl_pkg;

    localparam int HP_W          = 8;
    localparam int HP_MAX_DEF    = 200;
    localparam int DRAIN_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ATTACK = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_DODGE  = 3'd4,
        ST_DEAD   = 3'd5
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HP_W-1:0] sat_inc(input logic [HP_W-1:0] v);
        return (v == {HP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/enemy_hp_ctrl_hp_drain_timer.sv
// Drain prescaler: one-cycle tick every DIV clocks while not held in clear.
module hp_drain_timer
    import enemy_hp_ctrl_pkg::*;
#(
    parameter int DIV = DRAIN_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [7:0] TC = 8'(DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = !i_clear && (r_cnt == TC);

    // Count 0..DIV-1 and wrap; held at zero while cleared so each drain starts aligned.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= 8'd0;
        end else if (i_clear || (r_cnt == TC)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/enemy_hp_ctrl.sv
// Enemy HP turn controller: drains HP one point per prescaler tick, then
// clears the attack stage and hands over to the dodge phase until HP hits zero.
//
//   state  | meaning
//   IDLE   | waiting for go
//   ATTACK | attack stage enabled, waiting for its pass result
//   DRAIN  | removing latched damage one point per tick
//   CLEAR  | one-cycle reset pulse to the attack stage
//   DODGE  | dodge phase running, waiting for dodge_done
//   DEAD   | enemy HP exhausted, terminal until reset
module enemy_hp_ctrl
    import enemy_hp_ctrl_pkg::*;
#(
    parameter int HP_MAX    = HP_MAX_DEF,
    parameter int DRAIN_DIV = DRAIN_DIV_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_go,
    input  logic            i_atk_pass,
    input  logic [HP_W-1:0] i_atk_damage,
    input  logic            i_dodge_done,
    output logic            o_atk_start,
    output logic            o_atk_clear,
    output logic            o_dodge_start,
    output logic [HP_W-1:0] o_hp,
    output logic [HP_W-1:0] o_turn,
    output logic            o_enemy_dead
);

    state_t          r_state;
    state_t          w_state_next;
    logic [HP_W-1:0] r_hp;
    logic [HP_W-1:0] r_pending;
    logic [HP_W-1:0] r_turn;
    logic            w_tick;

    hp_drain_timer #(
        .DIV (DRAIN_DIV)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (r_state != ST_DRAIN),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the lethal check wins over the end-of-damage check on a tick.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_go) w_state_next = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (i_atk_pass) begin
                    w_state_next = (i_atk_damage == '0) ? ST_CLEAR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_tick) begin
                    if (r_hp <= 8'd1) begin
                        w_state_next = ST_DEAD;
                    end else if (r_pending <= 8'd1) begin
                        w_state_next = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: w_state_next = ST_DODGE;
            ST_DODGE: begin
                if (i_dodge_done) w_state_next = ST_ATTACK;
            end
            ST_DEAD:  w_state_next = ST_DEAD;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // HP, pending damage and turn counters.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hp      <= HP_W'(HP_MAX);
            r_pending <= '0;
            r_turn    <= '0;
        end else begin
            if ((r_state == ST_ATTACK) && i_atk_pass) begin
                r_pending <= i_atk_damage;
                r_turn    <= sat_inc(r_turn);
            end
            if ((r_state == ST_DRAIN) && w_tick) begin
                if (r_hp != '0)      r_hp      <= r_hp - 1'b1;
                if (r_pending != '0) r_pending <= r_pending - 1'b1;
            end
        end
    end

    // Moore outputs registered from the next state so they change with the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_atk_start   <= 1'b0;
            o_atk_clear   <= 1'b0;
            o_dodge_start <= 1'b0;
            o_enemy_dead  <= 1'b0;
        end else begin
            o_atk_start   <= (w_state_next == ST_ATTACK);
            o_atk_clear   <= (w_state_next == ST_CLEAR);
            o_dodge_start <= (w_state_next == ST_DODGE);
            o_enemy_dead  <= (w_state_next == ST_DEAD);
        end
    end

    assign o_hp   = r_hp;
    assign o_turn = r_turn;

endmodule

// File: tb/tb_enemy_hp_ctrl.sv
// Bench for enemy_hp_ctrl: vector table plus multi-cycle drain/reset/overkill sequences.
module tb_enemy_hp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       pass = 1'b0;
    logic       dodge_done = 1'b0;
    logic [7:0] dmg = 8'd0;

    logic       start_a, clear_a, dodge_a, dead_a;
    logic [7:0] hp_a, turn_a;
    logic       start_b, clear_b, dodge_b, dead_b;
    logic [7:0] hp_b, turn_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enemy_hp_ctrl #(.HP_MAX(200), .DRAIN_DIV(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_go(go), .i_atk_pass(pass),
        .i_atk_damage(dmg), .i_dodge_done(dodge_done),
        .o_atk_start(start_a), .o_atk_clear(clear_a), .o_dodge_start(dodge_a),
        .o_hp(hp_a), .o_turn(turn_a), .o_enemy_dead(dead_a)
    );

    enemy_hp_ctrl #(.HP_MAX(15), .DRAIN_DIV(4)) dut_ok (
        .i_clk(clk), .i_reset(rst_n), .i_go(go), .i_atk_pass(pass),
        .i_atk_damage(dmg), .i_dodge_done(dodge_done),
        .o_atk_start(start_b), .o_atk_clear(clear_b), .o_dodge_start(dodge_b),
        .o_hp(hp_b), .o_turn(turn_b), .o_enemy_dead(dead_b)
    );

    typedef struct {
        logic       go;
        logic       pass;
        logic [7:0] dmg;
        logic       dd;
        logic       e_start;
        logic       e_clear;
        logic       e_dodge;
        logic       e_dead;
        logic [7:0] e_hp;
        logic [7:0] e_turn;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        go = 1'b0; pass = 1'b0; dmg = 8'd0; dodge_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [19:0] outs_a();
        return {start_a, clear_a, dodge_a, dead_a, hp_a, turn_a};
    endfunction

    initial begin
        int bad;
        int waited;
        logic seen;

        // in       go pass dmg dd | start clear dodge dead hp turn
        vecs[0]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd200, 8'd1};
        vecs[5]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd200, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd2};
        vecs[8]  = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd2};
        vecs[9]  = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd2};
        vecs[10] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd2};
        vecs[11] = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd199, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd199, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd199, 8'd2};

        // Reset state, sampled while reset is held.
        do_reset();
        rst_n = 1'b0;
        step();
        check("reset outputs", outs_a(), {4'b0000, 8'd200, 8'd0});
        check("reset hp small", hp_b, 8'd15);
        rst_n = 1'b1;
        step();

        // Table: miss turn, spurious inputs, one-point drain.
        for (int i = 0; i < 14; i++) begin
            go = vecs[i].go; pass = vecs[i].pass; dmg = vecs[i].dmg; dodge_done = vecs[i].dd;
            step();
            check($sformatf("vec[%0d]", i), outs_a(),
                  {vecs[i].e_start, vecs[i].e_clear, vecs[i].e_dodge, vecs[i].e_dead,
                   vecs[i].e_hp, vecs[i].e_turn});
        end

        // Damage 20: one point every 4 clocks, clear pulse on the last, then dodge.
        do_reset();
        go = 1'b1;
        step();
        check("A atk_start", start_a, 1'b1);
        go = 1'b0; pass = 1'b1; dmg = 8'd20;
        step();
        check("A pass edge", {start_a, turn_a, hp_a}, {1'b0, 8'd1, 8'd200});
        for (int k = 1; k <= 80; k++) begin
            step();
            check($sformatf("A drain k=%0d", k), {hp_a, clear_a, dodge_a, start_a},
                  {8'(200 - k / 4), (k == 80), 1'b0, 1'b0});
        end
        pass = 1'b0;
        step();
        check("A dodge", {clear_a, dodge_a, turn_a, hp_a}, {1'b0, 1'b1, 8'd1, 8'd180});

        // Full loop: three turns of 10 damage.
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0;
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            waited = 0;
            while (!start_a && waited < 10) begin step(); waited++; end
            check($sformatf("B wait start t=%0d", t), start_a, 1'b1);
            pass = 1'b1; dmg = 8'd10;
            step();
            waited = 0;
            seen = 1'b0;
            while (waited < 60 && !seen) begin
                if (start_a) bad++;
                if (clear_a) seen = 1'b1;
                else begin step(); waited++; end
            end
            check($sformatf("B clear t=%0d", t), seen, 1'b1);
            pass = 1'b0;
            step();
            if (start_a && dodge_a) bad++;
            check($sformatf("B dodge t=%0d", t), dodge_a, 1'b1);
            dodge_done = 1'b1;
            step();
            dodge_done = 1'b0;
        end
        check("B final", {hp_a, turn_a, start_a, dodge_a}, {8'd170, 8'd3, 1'b1, 1'b0});
        check("B atk_start only in ATTACK", bad, 0);

        // Async reset in the middle of a drain.
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0; pass = 1'b1; dmg = 8'd15;
        step();
        for (int k = 0; k < 40; k++) step();
        check("C hp before reset", hp_a, 8'd190);
        #2 rst_n = 1'b0;
        #1 check("C async reset", outs_a(), {4'b0000, 8'd200, 8'd0});
        @(negedge clk);
        rst_n = 1'b1;
        dodge_done = 1'b1; pass = 1'b1; dmg = 8'd7;
        for (int k = 0; k < 3; k++) step();
        check("C ignored in IDLE", outs_a(), {4'b0000, 8'd200, 8'd0});
        dodge_done = 1'b0; pass = 1'b0; go = 1'b1;
        step();
        check("C go after reset", {start_a, hp_a}, {1'b1, 8'd200});
        go = 1'b0;

        // Overkill on the HP_MAX=15 instance.
        do_reset();
        go = 1'b1;
        step();
        go = 1'b0; pass = 1'b1; dmg = 8'd20;
        step();
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (clear_b || dodge_b) bad++;
            if (k == 59) check("D before lethal", {hp_b, dead_b}, {8'd1, 1'b0});
        end
        check("D lethal", {hp_b, dead_b, start_b}, {8'd0, 1'b1, 1'b0});
        dodge_done = 1'b1; go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (clear_b || dodge_b) bad++;
        end
        check("D stays dead", {hp_b, dead_b, start_b, turn_b}, {8'd0, 1'b1, 1'b0, 8'd1});
        check("D no clear/dodge", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enemy_hp_ctrl.md
# enemy_hp_ctrl

Battle-turn controller downstream of the attack-gauge stage. It consumes that stage's `pass`/`damage` result and drains the enemy's HP one point at a time so the HP bar animates. It then clears the attack stage, hands control to the dodge phase, and loops turns until enemy HP reaches zero. It also drives the attack stage's `start`.

## Interface
- `HP_MAX`, 200: enemy starting HP, 1..255.
- `DRAIN_DIV`, 4: clocks per 1-point HP decrement, 1..255.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces reset state immediately.
- `go` input 1: level; begin battle when in IDLE.
- `atk_pass` input 1: attack stage finished (level, held until stage cleared).
- `atk_damage` input 8: damage from attack stage, valid while `atk_pass`=1.
- `dodge_done` input 1: dodge phase finished (level).
- `atk_start` output 1: enable to attack stage; 1 only in ATTACK.
- `atk_clear` output 1: one-cycle pulse, wired (inverted as needed) to attack-stage reset.
- `dodge_start` output 1: 1 only in DODGE.
- `hp` output 8: current enemy HP.
- `turn` output 8: completed attack turns, saturates at 255.
- `enemy_dead` output 1: 1 in DEAD.

## Operation
- States: IDLE, ATTACK, DRAIN, CLEAR, DODGE, DEAD. Registered Moore outputs.
- Reset values:
  - State IDLE.
  - `hp`=HP_MAX, `turn`=0.
  - `atk_start`, `atk_clear`, `dodge_start`, `enemy_dead` all 0.
  - Internal `pending`=0 and drain counter=0.
- IDLE: `go`=1 → ATTACK.
- ATTACK: wait for `atk_pass`=1. In that cycle:
  - Latch `pending`=`atk_damage`.
  - `turn`+1, saturating.
  - If `atk_damage`=0 → CLEAR, otherwise → DRAIN.
- DRAIN: counter counts 0..DRAIN_DIV-1. On wrap:
  - `hp`-1 and `pending`-1.
  - If the new `hp`=0 → DEAD.
  - Else if the new `pending`=0 → CLEAR.
- Overkill: when `pending` > `hp`, draining stops at `hp`=0. `hp` never wraps below 0.
- CLEAR: exactly one cycle with `atk_clear`=1, then → DODGE. Its purpose is to clear the attack stage's `pass`/gauge.
- DODGE: `dodge_start`=1 until `dodge_done`=1 → ATTACK. `dodge_done` is ignored in every other state.
- DEAD: terminal; only `reset` exits. `atk_start`=0 and `enemy_dead`=1.
- `go` is ignored outside IDLE. `atk_pass` is ignored outside ATTACK.
- Width rules: all arithmetic is 8-bit unsigned. `pending` is compared against `hp` before each decrement.
- Reset mid-DRAIN: `hp` returns to HP_MAX and the latched damage is discarded.

## Timing
- `go` sampled at edge N → `atk_start`=1 from edge N+1.
- `atk_pass` sampled at edge N:
  - Nonzero damage → state DRAIN from N+1. First decrement visible after edge N+DRAIN_DIV. Damage D completes in D·DRAIN_DIV cycles.
  - Zero damage → `atk_clear`=1 for cycle N+1 only.
- Final decrement at edge M → `atk_clear` high during M+1, `dodge_start` high from M+2.
- `atk_start` drops the cycle after `atk_pass` is seen, so the attack stage freezes its outputs.
- `dodge_done` at edge K → `atk_start`=1 from K+1, `dodge_start`=0 from K+1.
- Lethal decrement at edge M → `enemy_dead`=1 from M+1. No `atk_clear` and no `dodge_start` are issued.

## Structure
- Shared battle package holds:
  - State encoding typedef (3-bit).
  - Constants HP_MAX default, DRAIN_DIV default, and the 8-bit HP width.
- The attack stage and HUD renderer use the same package.
- One natural sub-module: `hp_drain_timer`, the DRAIN_DIV prescaler emitting a one-cycle `tick`. Its `clear` input is active on DRAIN entry.

## Test plan
- Reset then `go`, `atk_pass`=1 with `atk_damage`=20, DRAIN_DIV=4:
  - `hp` falls 200→180 over 80 cycles, one step every 4.
  - `atk_clear` pulse 1 cycle, then `dodge_start`=1, `turn`=1.
- Miss: `atk_damage`=0 → `hp` stays 200, `atk_clear` the cycle after pass, then DODGE.
- Overkill: HP_MAX=15, damage 20 → `hp` reaches 0 after 60 cycles, `enemy_dead`=1, no `atk_clear`, no `dodge_start`.
- Full loop: three turns of damage 10 with `dodge_done` pulses → `hp`=170, `turn`=3. `atk_start` is high in ATTACK only.
- Async reset asserted mid-DRAIN (hp=190, pending 5) → immediately `hp`=200, all outputs 0, IDLE. `dodge_done` and `atk_pass` are ignored until `go`.
- Spurious inputs: `dodge_done`=1 in ATTACK, `atk_pass`=1 in DODGE, `go`=1 in DRAIN → no state change.
